// File: rtl/dcache_tag_ary_nway_if.sv
// -----------------------------------------------------------------------------
// dcache_tag_ary_nway_if
// Bundle of lookup, refill, dirty-mark and flush signals between the dCache
// control FSM (master) and the N-way tag store (slave).
//   Lookup  : i_lkp_valid/i_lkp_idx/i_lkp_tag -> o_lkp_valid/hit/way/dirty/vic_tag
//   Refill  : i_wr_en/i_wr_idx/i_wr_way/i_wr_tag/i_wr_dirty
//   Dirty   : i_dty_en/i_dty_idx/i_dty_way
//   Flush   : i_flush_req -> o_flush_busy/o_flush_done, o_ready
// -----------------------------------------------------------------------------
interface dcache_tag_ary_nway_if #(
    parameter int TAG_W = 52,
    parameter int SETS  = 128,
    parameter int WAYS  = 2
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic             i_lkp_valid;
    logic [IDX_W-1:0] i_lkp_idx;
    logic [TAG_W-1:0] i_lkp_tag;
    logic             o_lkp_valid;
    logic             o_lkp_hit;
    logic [WAY_W-1:0] o_lkp_way;
    logic             o_lkp_dirty;
    logic [TAG_W-1:0] o_lkp_vic_tag;

    logic             i_wr_en;
    logic [IDX_W-1:0] i_wr_idx;
    logic [WAY_W-1:0] i_wr_way;
    logic [TAG_W-1:0] i_wr_tag;
    logic             i_wr_dirty;

    logic             i_dty_en;
    logic [IDX_W-1:0] i_dty_idx;
    logic [WAY_W-1:0] i_dty_way;

    logic             i_flush_req;
    logic             o_flush_busy;
    logic             o_flush_done;
    logic             o_ready;

    modport master (
        output i_lkp_valid, i_lkp_idx, i_lkp_tag,
        output i_wr_en, i_wr_idx, i_wr_way, i_wr_tag, i_wr_dirty,
        output i_dty_en, i_dty_idx, i_dty_way,
        output i_flush_req,
        input  o_lkp_valid, o_lkp_hit, o_lkp_way, o_lkp_dirty, o_lkp_vic_tag,
        input  o_flush_busy, o_flush_done, o_ready
    );

    modport slave (
        input  i_lkp_valid, i_lkp_idx, i_lkp_tag,
        input  i_wr_en, i_wr_idx, i_wr_way, i_wr_tag, i_wr_dirty,
        input  i_dty_en, i_dty_idx, i_dty_way,
        input  i_flush_req,
        output o_lkp_valid, o_lkp_hit, o_lkp_way, o_lkp_dirty, o_lkp_vic_tag,
        output o_flush_busy, o_flush_done, o_ready
    );
endinterface

// File: rtl/dcache_tag_ary_nway.sv
// -----------------------------------------------------------------------------
// dcache_tag_ary_nway
// N-way set-associative tag store (flip-flop based). Per set/way it keeps tag,
// valid and dirty; per set a round-robin replacement pointer. A lookup is
// registered (one-cycle latency) and returns either the hit way or the
// replacement victim together with its stored tag and dirty flag. A two-state
// sequencer invalidates one set per cycle on a flush request.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : dcache_tag_ary_nway_if.slave (lookup, refill, dirty mark, flush)
// -----------------------------------------------------------------------------
module dcache_tag_ary_nway #(
    parameter int TAG_W = 52,
    parameter int SETS  = 128,
    parameter int WAYS  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dcache_tag_ary_nway_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_FLUSH = 1'b1;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    // Round-robin successor of a refilled way; wraps naturally for power-of-two WAYS.
    function automatic logic [WAY_W-1:0] next_rr(input logic [WAY_W-1:0] way);
        logic [WAY_W-1:0] nxt;
        if (WAYS == 1) begin
            nxt = {WAY_W{1'b0}};
        end else begin
            nxt = way + WAY_W'(1'b1);
        end
        return nxt;
    endfunction

    // Storage
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];

    // Flush sequencer
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Registered lookup result
    logic             lkp_valid_q, lkp_valid_d;
    logic             lkp_hit_q, lkp_hit_d;
    logic [WAY_W-1:0] lkp_way_q, lkp_way_d;
    logic             lkp_dirty_q, lkp_dirty_d;
    logic [TAG_W-1:0] lkp_vic_tag_q, lkp_vic_tag_d;

    // Request qualification: everything is ignored while flushing
    logic             idle_s;
    logic             lkp_acc_s;
    logic             wr_acc_s;
    logic             dty_acc_s;

    // Combinational lookup against the current (pre-edge) state
    logic             hit_s;
    logic [WAY_W-1:0] hit_way_s;
    logic             inv_found_s;
    logic [WAY_W-1:0] inv_way_s;
    logic [WAY_W-1:0] rep_way_s;

    assign idle_s    = (state_q == ST_IDLE);
    assign lkp_acc_s = bus.i_lkp_valid & idle_s;
    assign wr_acc_s  = bus.i_wr_en & idle_s;
    assign dty_acc_s = bus.i_dty_en & idle_s;

    // Tag compare and victim selection; descending scan leaves the lowest index.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = {WAY_W{1'b0}};
        inv_found_s = 1'b0;
        inv_way_s   = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[bus.i_lkp_idx][w] && (tag_q[bus.i_lkp_idx][w] == bus.i_lkp_tag)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (!valid_q[bus.i_lkp_idx][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_W'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        if (hit_s) begin
            rep_way_s = hit_way_s;
        end else if (inv_found_s) begin
            rep_way_s = inv_way_s;
        end else begin
            rep_way_s = rr_q[bus.i_lkp_idx];
        end
    end

    // Next lookup result: load on an accepted request, otherwise hold.
    always_comb begin
        lkp_valid_d   = lkp_acc_s;
        lkp_hit_d     = lkp_hit_q;
        lkp_way_d     = lkp_way_q;
        lkp_dirty_d   = lkp_dirty_q;
        lkp_vic_tag_d = lkp_vic_tag_q;
        if (lkp_acc_s) begin
            lkp_hit_d     = hit_s;
            lkp_way_d     = rep_way_s;
            // An invalid way never reports dirty, even if a stale bit remained.
            lkp_dirty_d   = valid_q[bus.i_lkp_idx][rep_way_s] & dirty_q[bus.i_lkp_idx][rep_way_s];
            lkp_vic_tag_d = tag_q[bus.i_lkp_idx][rep_way_s];
        end else begin
            lkp_hit_d     = lkp_hit_q;
        end
    end

    // Flush sequencer next state: one set per cycle, done pulse after the last set.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {IDX_W{1'b0}};
                if (bus.i_flush_req) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                    cnt_d   = {IDX_W{1'b0}};
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Sequencer and lookup-result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {IDX_W{1'b0}};
            done_q        <= 1'b0;
            lkp_valid_q   <= 1'b0;
            lkp_hit_q     <= 1'b0;
            lkp_way_q     <= {WAY_W{1'b0}};
            lkp_dirty_q   <= 1'b0;
            lkp_vic_tag_q <= {TAG_W{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            lkp_valid_q   <= lkp_valid_d;
            lkp_hit_q     <= lkp_hit_d;
            lkp_way_q     <= lkp_way_d;
            lkp_dirty_q   <= lkp_dirty_d;
            lkp_vic_tag_q <= lkp_vic_tag_d;
        end
    end

    // Valid/dirty/round-robin state; the refill is written last so it overrides a dirty mark.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
                dirty_q[s] <= {WAYS{1'b0}};
                rr_q[s]    <= {WAY_W{1'b0}};
            end
        end else if (state_q == ST_FLUSH) begin
            valid_q[cnt_q] <= {WAYS{1'b0}};
            dirty_q[cnt_q] <= {WAYS{1'b0}};
            rr_q[cnt_q]    <= {WAY_W{1'b0}};
        end else begin
            if (dty_acc_s) begin
                dirty_q[bus.i_dty_idx][bus.i_dty_way] <= 1'b1;
            end
            if (wr_acc_s) begin
                valid_q[bus.i_wr_idx][bus.i_wr_way] <= 1'b1;
                dirty_q[bus.i_wr_idx][bus.i_wr_way] <= bus.i_wr_dirty;
                rr_q[bus.i_wr_idx]                  <= next_rr(bus.i_wr_way);
            end
        end
    end

    // Tag storage; tags survive a flush and are only changed by refills.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= {TAG_W{1'b0}};
                end
            end
        end else if (wr_acc_s) begin
            tag_q[bus.i_wr_idx][bus.i_wr_way] <= bus.i_wr_tag;
        end
    end

    assign bus.o_lkp_valid   = lkp_valid_q;
    assign bus.o_lkp_hit     = lkp_hit_q;
    assign bus.o_lkp_way     = lkp_way_q;
    assign bus.o_lkp_dirty   = lkp_dirty_q;
    assign bus.o_lkp_vic_tag = lkp_vic_tag_q;
    assign bus.o_flush_busy  = (state_q == ST_FLUSH);
    assign bus.o_flush_done  = done_q;
    assign bus.o_ready       = (state_q != ST_FLUSH);

endmodule

// File: tb/tb_dcache_tag_ary_nway.sv
// -----------------------------------------------------------------------------
// tb_dcache_tag_ary_nway
// Directed bench for the N-way tag store. Each accepted lookup pushes its
// expected result into a scoreboard queue; a monitor on the falling clock edge
// pops and compares whenever o_lkp_valid is seen.
// -----------------------------------------------------------------------------
module tb_dcache_tag_ary_nway;
    localparam int TAG_W = 52;
    localparam int SETS  = 128;
    localparam int WAYS  = 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct {
        logic             hit;
        logic [WAY_W-1:0] way;
        logic             dirty;
        logic [TAG_W-1:0] vt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    exp_t sb_q[$];

    dcache_tag_ary_nway_if #(.TAG_W(TAG_W), .SETS(SETS), .WAYS(WAYS)) bus ();

    dcache_tag_ary_nway #(.TAG_W(TAG_W), .SETS(SETS), .WAYS(WAYS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every produced lookup result with the oldest expectation.
    always @(negedge clk) begin
        if (bus.o_lkp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("lkp_unexpected", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("lkp_hit",   64'(bus.o_lkp_hit),     64'(e.hit));
                check_eq("lkp_way",   64'(bus.o_lkp_way),     64'(e.way));
                check_eq("lkp_dirty", 64'(bus.o_lkp_dirty),   64'(e.dirty));
                check_eq("lkp_vtag",  64'(bus.o_lkp_vic_tag), 64'(e.vt));
            end
        end
    end

    task automatic clr_strobes();
        bus.i_lkp_valid = 1'b0;
        bus.i_wr_en     = 1'b0;
        bus.i_dty_en    = 1'b0;
        bus.i_flush_req = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr_strobes();
    endtask

    task automatic lkp(input int idx, input longint tag, input int e_hit, input int e_way,
                       input int e_dirty, input longint e_vt);
        exp_t e;
        bus.i_lkp_valid = 1'b1;
        bus.i_lkp_idx   = IDX_W'(idx);
        bus.i_lkp_tag   = TAG_W'(tag);
        e.hit   = 1'(e_hit);
        e.way   = WAY_W'(e_way);
        e.dirty = 1'(e_dirty);
        e.vt    = TAG_W'(e_vt);
        sb_q.push_back(e);
    endtask

    task automatic wr(input int idx, input int way, input longint tag, input int dirty);
        bus.i_wr_en    = 1'b1;
        bus.i_wr_idx   = IDX_W'(idx);
        bus.i_wr_way   = WAY_W'(way);
        bus.i_wr_tag   = TAG_W'(tag);
        bus.i_wr_dirty = 1'(dirty);
    endtask

    task automatic dty(input int idx, input int way);
        bus.i_dty_en  = 1'b1;
        bus.i_dty_idx = IDX_W'(idx);
        bus.i_dty_way = WAY_W'(way);
    endtask

    initial begin
        int done_cnt;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr_strobes();
        bus.i_lkp_idx  = '0;
        bus.i_lkp_tag  = '0;
        bus.i_wr_idx   = '0;
        bus.i_wr_way   = '0;
        bus.i_wr_tag   = '0;
        bus.i_wr_dirty = 1'b0;
        bus.i_dty_idx  = '0;
        bus.i_dty_way  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_lkp_valid", 64'(bus.o_lkp_valid), 64'(0));
        check_eq("rst_hit",       64'(bus.o_lkp_hit),   64'(0));
        check_eq("rst_vtag",      64'(bus.o_lkp_vic_tag), 64'(0));
        check_eq("rst_busy",      64'(bus.o_flush_busy), 64'(0));
        check_eq("rst_done",      64'(bus.o_flush_done), 64'(0));
        check_eq("rst_ready",     64'(bus.o_ready),      64'(1));

        // Cold lookup misses into way 0
        lkp(5, 'h123, 0, 0, 0, 0);                      cyc();
        // Refill, hit, dirty mark, hit dirty
        wr(5, 0, 'h123, 0);                             cyc();
        lkp(5, 'h123, 1, 0, 0, 'h123);                  cyc();
        dty(5, 0);                                      cyc();
        lkp(5, 'h123, 1, 0, 1, 'h123);                  cyc();
        cyc();
        // Outputs hold once o_lkp_valid drops
        check_eq("hold_valid", 64'(bus.o_lkp_valid), 64'(0));
        check_eq("hold_hit",   64'(bus.o_lkp_hit),   64'(1));
        check_eq("hold_dirty", 64'(bus.o_lkp_dirty), 64'(1));

        // Round-robin replacement
        wr(5, 0, 'hA, 0);                               cyc();
        wr(5, 1, 'hB, 0);                               cyc();
        lkp(5, 'hC, 0, 0, 0, 'hA);                      cyc();
        wr(5, 0, 'hC, 0);                               cyc();
        lkp(5, 'hD, 0, 1, 0, 'hB);                      cyc();
        dty(5, 1);                                      cyc();
        lkp(5, 'hE, 0, 1, 1, 'hB);                      cyc();

        // Same-cycle lookup and refill: no bypass
        lkp(7, 'h55, 0, 0, 0, 0);
        wr(7, 0, 'h55, 0);                              cyc();
        lkp(7, 'h55, 1, 0, 0, 'h55);                    cyc();
        // Refill beats dirty mark on the same set/way
        wr(7, 1, 'h66, 0);
        dty(7, 1);                                      cyc();
        lkp(7, 'h66, 1, 1, 0, 'h66);                    cyc();
        // Back-to-back lookup, then refill and dirty mark on different ways
        lkp(7, 'h55, 1, 0, 0, 'h55);
        wr(7, 1, 'h66, 0);
        dty(7, 0);                                      cyc();
        lkp(7, 'h55, 1, 0, 1, 'h55);                    cyc();
        lkp(7, 'h66, 1, 1, 0, 'h66);                    cyc();

        // Flush: fill boundary sets dirty first
        wr(0, 0, 'h11, 1);                              cyc();
        wr(SETS - 1, 1, 'h22, 1);                       cyc();
        // Cycle F: flush request plus a lookup that is still accepted
        bus.i_flush_req = 1'b1;
        lkp(0, 'h11, 1, 0, 1, 'h11);                    cyc();
        for (int k = 0; k < SETS; k++) begin
            check_eq("flush_busy",  64'(bus.o_flush_busy), 64'(1));
            check_eq("flush_ready", 64'(bus.o_ready),      64'(0));
            if (k == 10) begin
                // All of these must be ignored while busy
                wr(0, 1, 'h77, 1);
                dty(0, 0);
                bus.i_lkp_valid = 1'b1;
                bus.i_lkp_idx   = IDX_W'(0);
                bus.i_flush_req = 1'b1;
            end
            cyc();
        end
        check_eq("flush_end_busy",  64'(bus.o_flush_busy), 64'(0));
        check_eq("flush_end_ready", 64'(bus.o_ready),      64'(1));
        check_eq("flush_done",      64'(bus.o_flush_done), 64'(1));
        cyc();
        check_eq("flush_done_pulse", 64'(bus.o_flush_done), 64'(0));
        // Post-flush: everything invalid, tags retained, dirty cleared
        lkp(0, 'h11, 0, 0, 0, 'h11);                    cyc();
        lkp(SETS - 1, 'h22, 0, 0, 0, 0);                cyc();
        lkp(0, 'h77, 0, 0, 0, 'h11);                    cyc();
        lkp(5, 'hC, 0, 0, 0, 'hC);                      cyc();

        // Reset in the middle of a flush
        wr(9, 1, 'h99, 1);                              cyc();
        bus.i_flush_req = 1'b1;                         cyc();
        repeat (39) cyc();
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy",  64'(bus.o_flush_busy), 64'(0));
        check_eq("abort_ready", 64'(bus.o_ready),      64'(1));
        check_eq("abort_done",  64'(bus.o_flush_done), 64'(0));
        cyc();
        cyc();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < SETS + 4; k++) begin
            if (bus.o_flush_done === 1'b1) done_cnt++;
            cyc();
        end
        check_eq("abort_no_done", 64'(done_cnt), 64'(0));
        check_eq("abort_ready_after", 64'(bus.o_ready), 64'(1));
        lkp(9, 'h99, 0, 0, 0, 0);                       cyc();
        lkp(0, 'h11, 0, 0, 0, 0);                       cyc();
        lkp(5, 'hC, 0, 0, 0, 0);                        cyc();

        cyc();
        cyc();
        check_eq("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_tag_ary_nway.md
# dcache_tag_ary_nway

Parametrised N-way set-associative tag store for the data cache, successor to the single-way register-based tag array. Holds tag, valid and dirty state per set/way, performs a registered lookup returning hit way or replacement victim (with victim tag and dirty flag for writeback), and contains a multi-cycle invalidate-all sequencer. Sits between the dCache control FSM and the data SRAMs; storage is flip-flop based with asynchronous reset.

## Interface
- TAG_W, 52: tag width in bits.
- SETS, 128: number of sets; power of two, ≥2. IDX_W = $clog2(SETS) (localparam).
- WAYS, 2: associativity; power of two, 1..8. WAY_W = max(1, $clog2(WAYS)) (localparam).

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_lkp_valid  in  1  lookup request; accepted only when o_ready=1.
- i_lkp_idx  in  IDX_W  lookup set index.
- i_lkp_tag  in  TAG_W  lookup tag.
- o_lkp_valid  out  1  lookup result valid (one-cycle pulse).
- o_lkp_hit  out  1  tag matched a valid way.
- o_lkp_way  out  WAY_W  hit way on hit, victim way on miss.
- o_lkp_dirty  out  1  dirty bit of the reported way (valid ways only, else 0).
- o_lkp_vic_tag  out  TAG_W  stored tag of the reported way.
- i_wr_en  in  1  refill write: set valid=1, load tag and dirty.
- i_wr_idx  in  IDX_W, i_wr_way  in  WAY_W, i_wr_tag  in  TAG_W, i_wr_dirty  in  1  refill target and contents.
- i_dty_en  in  1  mark way dirty (store hit).
- i_dty_idx  in  IDX_W, i_dty_way  in  WAY_W  dirty-mark target.
- i_flush_req  in  1  start invalidate-all.
- o_flush_busy  out  1  invalidate sequencer active.
- o_flush_done  out  1  one-cycle pulse on flush completion.
- o_ready  out  1  = !o_flush_busy.

## Operation
- Per set/way state: tag[TAG_W], valid, dirty. Per set: round-robin pointer rr[WAY_W].
- Lookup: hit if any way has valid=1 and tag==i_lkp_tag; multiple matches are illegal, lowest index reported.
- Miss victim: lowest-index way with valid=0; if all valid, way rr[idx].
- Refill (i_wr_en): tag/valid/dirty of (i_wr_idx, i_wr_way) written; rr[i_wr_idx] <= (i_wr_way+1) mod WAYS.
- Dirty mark (i_dty_en): dirty[i_dty_idx][i_dty_way] <= 1; valid and tag unchanged.
- Same set/way in i_wr_en and i_dty_en: refill wins; dirty = i_wr_dirty.
- FSM states IDLE, FLUSH.
  - IDLE -> FLUSH when i_flush_req=1; counter cleared to 0.
  - FLUSH: each cycle clears valid, dirty of all ways and rr of set[counter]; counter increments; after set SETS-1 cleared -> IDLE. Tags retained.
  - No writeback performed; controller writes back dirty lines before flushing.
- In FLUSH: i_lkp_valid, i_wr_en, i_dty_en, i_flush_req ignored; no o_lkp_valid generated.
- Reset: all valid, dirty, rr, tags = 0; FSM IDLE; counter 0; all outputs 0 (o_ready = 1 after reset).
- Reset asserted mid-flush: aborts, FSM IDLE, no o_flush_done pulse.

## Timing
- Lookup latency 1: request accepted in cycle N -> o_lkp_* valid in cycle N+1 only; o_lkp_* hold last values when o_lkp_valid=0.
- Lookup samples state before the cycle-N edge: a write or dirty mark to the same set in cycle N is not reflected in the result (no bypass).
- Refill/dirty mark take effect at the end of the issuing cycle; a lookup in N+1 sees them.
- Flush: i_flush_req in IDLE cycle F -> o_flush_busy=1 in cycles F+1..F+SETS; set k cleared at end of cycle F+1+k; cycle F+SETS+1: o_flush_busy=0, o_ready=1, o_flush_done=1 for exactly one cycle.
- Operations in cycle F (lookup, write, dirty mark) are accepted; lookup result appears in F+1 while busy.
- Back-to-back lookups: one per cycle, full throughput.

## Test plan
- Reset then lookup idx 5 tag 0x123 -> N+1: o_lkp_valid=1, hit=0, way=0, dirty=0, vic_tag=0.
- Refill (idx 5, way 0, tag 0x123, dirty 0); next cycle lookup tag 0x123 -> hit=1, way=0; then dirty mark (5,0), lookup -> hit=1, dirty=1.
- WAYS=2: refill (5,0,0xA) and (5,1,0xB); lookup tag 0xC -> miss, way=0 (rr=0 after way-1 refill), vic_tag=0xA; refill way 0 with 0xC, lookup 0xD -> way=1, vic_tag=0xB.
- Same-cycle lookup and refill to idx 7 tag 0x55 -> lookup reports miss; following lookup reports hit; simultaneous wr_en (dirty=0) and dty_en on same set/way -> dirty=0.
- Fill sets 0 and 127 dirty, flush at F -> busy F+1..F+128, done pulse at F+129; lookups/writes during busy ignored (no o_lkp_valid); post-flush lookups of old tags miss with dirty=0.
- Assert i_rst_n=0 at F+40 of a flush -> busy=0, done never pulses, all sets invalid, o_ready=1 after release.
